// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register-file peripheral.
// Frames are MSB first: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// Writes commit on the synchronised nCS rise once exactly FLEN bits have been shifted.
// Optional register readback on CIPO is enabled by defining SPI_REG_BANK_READ_EN.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_ncs,
  input  logic                         spi_copi,
  input  logic                         spi_sclk,
  output logic                         spi_cipo,
  output logic                         spi_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int FLEN  = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FLEN);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FLEN-1:0]         shreg;

  logic [SYNC_STAGES-1:0]  ncs_sync;
  logic [SYNC_STAGES-1:0]  copi_sync;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic                    ncs_hist;
  logic                    sclk_hist;

  // Synchronise every SPI input and keep one history flop for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_sync <= '0;
      ncs_hist  <= 1'b0;
      sclk_hist <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  spi_ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic ncs_s, copi_s, sclk_s;
  logic ncs_rise, ncs_fall, sclk_rise;

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_rise  =  ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s &  ncs_hist;
  // SCLK activity only counts while chip select is asserted.
  assign sclk_rise =  sclk_s & ~sclk_hist & ~ncs_s;

  logic [FLEN-1:0]   shreg_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              fr_rw;
  logic [ADDR_W-1:0] fr_addr;
  logic [DATA_W-1:0] fr_data;
  logic              addr_hit;

  assign shreg_nxt = {shreg[FLEN-2:0], copi_s};
  assign cnt_nxt   = bit_cnt + CNT_W'(1);
  assign fr_rw     = shreg[FLEN-1];
  assign fr_addr   = shreg[DATA_W +: ADDR_W];
  assign fr_data   = shreg[DATA_W-1:0];
  assign addr_hit  = {1'b0, fr_addr} < NUM_REGS_A;

  // Frame FSM: shifting, length checking, commit and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      // NOTE: the register file is cleared by reset because software expects known values at power-up.
      regs_out  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_FULL) state <= WAIT_CS;
          end
        end
        WAIT_CS: begin
          if (ncs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (fr_rw && addr_hit) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if ({1'b0, fr_addr} == (ADDR_W + 1)'(k)) regs_out[k*DATA_W +: DATA_W] <= fr_data;
              end
              wr_strobe <= 1'b1;
              wr_addr   <= fr_addr;
            end
          end else if (sclk_rise) begin
            state <= OVERRUN;
          end
        end
        OVERRUN: begin
          if (ncs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_REG_BANK_READ_EN
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);

  logic              sclk_fall;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_is_read;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] shout;

  assign sclk_fall  = ~sclk_s & sclk_hist & ~ncs_s;
  assign rd_addr    = shreg_nxt[ADDR_W-1:0];
  assign rd_is_read = ~shreg_nxt[ADDR_W];

  // Look up the register addressed by the frame being shifted in; unimplemented addresses read 0.
  always_comb begin
    // NOTE: default first so no path leaves rd_data unassigned (which would infer a latch).
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if ({1'b0, rd_addr} == (ADDR_W + 1)'(k)) rd_data = regs_out[k*DATA_W +: DATA_W];
    end
  end

  // Readback shifter: load when the address completes, advance on each SCLK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      shout       <= '0;
      spi_cipo_oe <= 1'b0;
    end else if (ncs_rise || state == IDLE) begin
      shout       <= '0;
      spi_cipo_oe <= 1'b0;
    end else if (state == SHIFT && sclk_rise && cnt_nxt == CNT_ADDR && rd_is_read) begin
      shout       <= rd_data;
      spi_cipo_oe <= 1'b1;
    end else if (spi_cipo_oe && sclk_fall) begin
      shout <= {shout[DATA_W-2:0], 1'b0};
    end
  end

  // The shifter is all-zero whenever it is not driving, so CIPO idles low.
  assign spi_cipo = shout[DATA_W-1];
`else
  assign spi_cipo    = 1'b0;
  assign spi_cipo_oe = 1'b0;
`endif

endmodule
